dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the core load/store path, port 1 is the debug/loader path that preloads and inspects data memory.
- Arbitrates with a 2-way round-robin, serializes every access, and routes read data back to the owner.
- Sits between the requesters and the data memory instance inside top.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- READ_LAT, 1, data memory read latency in cycles after the issue cycle; legal range 1..4.

Ports:
- CLK  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- m0_valid  input  1  port 0 request valid.
- m0_ready  output  1  port 0 request accepted.
- m0_we  input  1  port 0 write enable; 0 means read.
- m0_addr  input  AW  port 0 byte address.
- m0_wdata  input  DW  port 0 write data.
- m0_rdata  output  DW  port 0 read data.
- m0_rvalid  output  1  port 0 read data valid, one-cycle pulse.
- m1_valid, m1_ready, m1_we, m1_addr, m1_wdata, m1_rdata, m1_rvalid: same as port 0, for port 1.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data.

Behaviour:
- FSM states:
  - IDLE: accepts requests.
  - ISSUE: exactly one cycle; drives the memory.
  - WAIT: exactly READ_LAT cycles; reads only.
- IDLE:
  - If any mX_valid=1, select a winner and assert mX_ready=1 for the winner only, combinationally, in the same cycle.
  - The handshake completes on valid&ready.
  - Register we, addr and wdata, then go to ISSUE.
  - The loser's ready stays 0.
  - No request: stay in IDLE.
- Ready is 0 in every state other than IDLE. A requester holds valid and its payload stable until ready.
- Arbitration:
  - Pointer prf (1 bit, reset 0) names the preferred port.
  - Both valid: port prf wins.
  - One valid: that port wins.
  - After a grant to port k, prf becomes ~k.
- ISSUE:
  - mem_en=1, mem_we, mem_addr and mem_wdata come from the registered request.
  - Write: next state IDLE. No response is returned.
  - Read: next state WAIT; load the counter with READ_LAT.
- WAIT:
  - Decrement the counter every cycle.
  - In the cycle where the counter equals 1, assert m{owner}_rvalid=1, then go to IDLE.
- Owner register (1 bit) is captured at grant and used to route rvalid.
- m0_rdata and m1_rdata are both driven directly from mem_rdata. Only rvalid is steered.
- Latency:
  - Read: accept at cycle N, mem_en at N+1, rvalid at N+1+READ_LAT.
  - Write: accept at N, mem write at N+1.
  - Throughput: one write per 2 cycles; one read per 2+READ_LAT cycles.
- Outside ISSUE: mem_en=0 and mem_we=0. mem_addr and mem_wdata hold their last values.
- Reset values (rst=0, takes effect immediately):
  - state=IDLE, prf=0, owner=0, counter=0.
  - All ready, rvalid, mem_en and mem_we = 0.
  - mem_addr and mem_wdata = 0.
- Reset mid-operation: an in-flight read is dropped and no rvalid is emitted. An ISSUE-cycle write is abandoned with mem_we deasserted immediately.
- A request deasserting valid before ready is legal and simply loses its slot.

Optional Feature:
- Macro DMEM_ARB_CNT_EN.
- Defined:
  - Adds output ports gnt_cnt0[15:0] and gnt_cnt1[15:0].
  - Each counts grants to its port and saturates at 16'hFFFF.
  - Both reset to 0 on rst=0.
  - A counter increments in the grant cycle, so it is visible from the next cycle.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset check: assert rst=0 for 2 cycles during a pending read, then release -> all outputs 0, state IDLE, no rvalid; first subsequent request is granted in its first cycle.
- Port 0 read, READ_LAT=1: m0 read of addr h00002000, memory returns h00000005 -> m0_ready at N; mem_en=1, mem_we=0, mem_addr=h00002000 at N+1; m0_rvalid=1 with m0_rdata=h00000005 at N+2; m1_rvalid stays 0.
- Port 1 write: m1 writes h00000006 to h00002004 -> mem_en=mem_we=1 with that address and data at N+1; no rvalid; arbiter back in IDLE at N+2.
- Contention: m0 and m1 both assert reads continuously from reset -> grants alternate 0,1,0,1 for 4 transactions; each rvalid pulse goes to the matching owner.
- READ_LAT=3 with back-to-back m0 reads -> rvalid at N+4; m0_ready does not reassert before N+5.
- With DMEM_ARB_CNT_EN: 5 m0 grants and 3 m1 grants -> gnt_cnt0=5 and gnt_cnt1=3; a counter preloaded to hFFFF stays hFFFF after a further grant.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Optional grant counters are enabled by defining DMEM_ARB_CNT_EN.
module dmem_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned READ_LAT = 1
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          m0_valid,
  output logic          m0_ready,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_rvalid,
  input  logic          m1_valid,
  output logic          m1_ready,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_rvalid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
`ifdef DMEM_ARB_CNT_EN
  output logic [15:0]   gnt_cnt0,
  output logic [15:0]   gnt_cnt1,
`endif
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [2:0] LatInit = 3'(READ_LAT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e        state_q;
  logic          prf_q;
  logic          owner_q;
  logic          we_q;
  logic [2:0]    cnt_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          idle;
  logic          gnt0;
  logic          gnt1;

  // Ready is gated by rst so nothing is granted while reset is held.
  always_comb begin
    idle = (state_q == StIdle) && rst;
    gnt0 = idle && m0_valid && (!m1_valid || !prf_q);
    gnt1 = idle && m1_valid && (!m0_valid || prf_q);
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      prf_q   <= 1'b0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt0 || gnt1) begin
            owner_q <= gnt1;
            prf_q   <= ~gnt1;
            we_q    <= gnt1 ? m1_we : m0_we;
            addr_q  <= gnt1 ? m1_addr : m0_addr;
            wdata_q <= gnt1 ? m1_wdata : m0_wdata;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (we_q) begin
            state_q <= StIdle;
          end else begin
            cnt_q   <= LatInit;
            state_q <= StWait;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read data is broadcast; only the rvalid strobe is steered to the owner.
  always_comb begin
    m0_ready  = gnt0;
    m1_ready  = gnt1;
    mem_en    = (state_q == StIssue);
    mem_we    = (state_q == StIssue) && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    m0_rdata  = mem_rdata;
    m1_rdata  = mem_rdata;
    m0_rvalid = (state_q == StWait) && (cnt_q == 3'd1) && !owner_q;
    m1_rvalid = (state_q == StWait) && (cnt_q == 3'd1) && owner_q;
  end

`ifdef DMEM_ARB_CNT_EN
  logic [15:0] cnt0_q;
  logic [15:0] cnt1_q;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      cnt0_q <= 16'd0;
      cnt1_q <= 16'd0;
    end else begin
      if (gnt0 && (cnt0_q != 16'hFFFF)) cnt0_q <= cnt0_q + 16'd1;
      if (gnt1 && (cnt1_q != 16'hFFFF)) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (READ_LAT 1 and 3) share stimulus and
// are each checked every cycle against a schedule-based model.
module tb_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        rst = 1'b0;
  logic        m0_valid = 1'b0, m0_we = 1'b0, m1_valid = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [31:0] mem_rdata = '0;

  logic        a_m0_ready, a_m1_ready, a_m0_rvalid, a_m1_rvalid, a_mem_en, a_mem_we;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata;
  logic        b_m0_ready, b_m1_ready, b_m0_rvalid, b_m1_rvalid, b_mem_en, b_mem_we;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata;
`ifdef DMEM_ARB_CNT_EN
  logic [15:0] a_cnt0, a_cnt1, b_cnt0, b_cnt1;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 CLK = ~CLK;

  dmem_arbiter #(.AW(32), .DW(32), .READ_LAT(1)) u_a (
    .CLK(CLK), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(a_m0_ready), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(a_m0_rdata), .m0_rvalid(a_m0_rvalid),
    .m1_valid(m1_valid), .m1_ready(a_m1_ready), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(a_m1_rdata), .m1_rvalid(a_m1_rvalid),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
`ifdef DMEM_ARB_CNT_EN
    .gnt_cnt0(a_cnt0), .gnt_cnt1(a_cnt1),
`endif
    .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.AW(32), .DW(32), .READ_LAT(3)) u_b (
    .CLK(CLK), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(b_m0_ready), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(b_m0_rdata), .m0_rvalid(b_m0_rvalid),
    .m1_valid(m1_valid), .m1_ready(b_m1_ready), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(b_m1_rdata), .m1_rvalid(b_m1_rvalid),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
`ifdef DMEM_ARB_CNT_EN
    .gnt_cnt0(b_cnt0), .gnt_cnt1(b_cnt1),
`endif
    .mem_rdata(mem_rdata)
  );

  // Model: each instance is described by the cycle it is next free, the cycle
  // of its memory strobe and the cycle of its read response.
  int          free_c[2];
  int          issue_c[2];
  int          resp_c[2];
  bit          own_l[2];
  bit          we_l[2];
  bit          prf_m[2];
  logic [31:0] addr_l[2];
  logic [31:0] wd_l[2];
  int          cnt0_m[2];
  int          cnt1_m[2];

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input int i, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] cyc=%0d got=%0h want=%0h", nm, i, cyc, act, exp);
    end
  endtask

  task automatic model_reset(input int i);
    free_c[i] = 0; issue_c[i] = -1; resp_c[i] = -1;
    own_l[i] = 0; we_l[i] = 0; prf_m[i] = 0;
    addr_l[i] = '0; wd_l[i] = '0; cnt0_m[i] = 0; cnt1_m[i] = 0;
  endtask

  task automatic model_check(input int i);
    bit          e_r0, e_r1, e_en, e_we, e_rv0, e_rv1, idle;
    logic [31:0] e_addr, e_wd;
    bit          k;
    if (!rst) begin
      model_reset(i);
      {e_r0, e_r1, e_en, e_we, e_rv0, e_rv1} = '0;
      e_addr = '0; e_wd = '0;
    end else begin
      idle   = (cyc >= free_c[i]);
      e_r0   = idle && m0_valid && (!m1_valid || !prf_m[i]);
      e_r1   = idle && m1_valid && (!m0_valid || prf_m[i]);
      e_en   = (cyc == issue_c[i]);
      e_we   = e_en && we_l[i];
      e_addr = addr_l[i];
      e_wd   = wd_l[i];
      e_rv0  = (cyc == resp_c[i]) && !own_l[i];
      e_rv1  = (cyc == resp_c[i]) && own_l[i];
    end
    chk("m0_ready", i, (i == 0) ? a_m0_ready : b_m0_ready, e_r0);
    chk("m1_ready", i, (i == 0) ? a_m1_ready : b_m1_ready, e_r1);
    chk("mem_en", i, (i == 0) ? a_mem_en : b_mem_en, e_en);
    chk("mem_we", i, (i == 0) ? a_mem_we : b_mem_we, e_we);
    chk("mem_addr", i, (i == 0) ? a_mem_addr : b_mem_addr, e_addr);
    chk("mem_wdata", i, (i == 0) ? a_mem_wdata : b_mem_wdata, e_wd);
    chk("m0_rvalid", i, (i == 0) ? a_m0_rvalid : b_m0_rvalid, e_rv0);
    chk("m1_rvalid", i, (i == 0) ? a_m1_rvalid : b_m1_rvalid, e_rv1);
    if (e_rv0) chk("m0_rdata", i, (i == 0) ? a_m0_rdata : b_m0_rdata, mem_rdata);
    if (e_rv1) chk("m1_rdata", i, (i == 0) ? a_m1_rdata : b_m1_rdata, mem_rdata);
`ifdef DMEM_ARB_CNT_EN
    chk("gnt_cnt0", i, (i == 0) ? a_cnt0 : b_cnt0, cnt0_m[i]);
    chk("gnt_cnt1", i, (i == 0) ? a_cnt1 : b_cnt1, cnt1_m[i]);
`endif
    if (rst && (e_r0 || e_r1)) begin
      k          = e_r1;
      issue_c[i] = cyc + 1;
      we_l[i]    = k ? m1_we : m0_we;
      addr_l[i]  = k ? m1_addr : m0_addr;
      wd_l[i]    = k ? m1_wdata : m0_wdata;
      prf_m[i]   = !k;
      if (k) cnt1_m[i] = (cnt1_m[i] < 65535) ? cnt1_m[i] + 1 : 65535;
      else   cnt0_m[i] = (cnt0_m[i] < 65535) ? cnt0_m[i] + 1 : 65535;
      if (we_l[i]) begin
        free_c[i] = cyc + 2;
      end else begin
        own_l[i]  = k;
        resp_c[i] = cyc + 1 + lat_of(i);
        free_c[i] = cyc + 2 + lat_of(i);
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then check both instances.
  task automatic step(input bit r, input bit v0, input bit w0, input logic [31:0] ad0,
                      input logic [31:0] dd0, input bit v1, input bit w1,
                      input logic [31:0] ad1, input logic [31:0] dd1,
                      input logic [31:0] rd);
    @(negedge CLK);
    rst = r;
    m0_valid = v0; m0_we = w0; m0_addr = ad0; m0_wdata = dd0;
    m1_valid = v1; m1_we = w1; m1_addr = ad1; m1_wdata = dd1;
    mem_rdata = rd;
    #1;
    for (int i = 0; i < 2; i++) model_check(i);
    cyc++;
  endtask

  task automatic idle_steps(input int n);
    for (int j = 0; j < n; j++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, $urandom);
  endtask

  typedef struct {
    bit v0; bit v1; logic [31:0] a0; logic [31:0] a1; bit r0; bit r1;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1);
  end

  initial begin
    int gseq[8];
    int ng;
    int nrv;
    bit q[$];
    bit own;
    int gc[$];
    int rc[$];

    // Writes from both ports, prf starting at 0 after reset.
    tbl[0] = '{1, 1, 32'h10, 32'h20, 1, 0};
    tbl[1] = '{1, 1, 32'h14, 32'h24, 0, 1};
    tbl[2] = '{0, 1, 32'h18, 32'h28, 0, 1};
    tbl[3] = '{1, 1, 32'h1c, 32'h2c, 1, 0};
    tbl[4] = '{1, 0, 32'h30, 32'h40, 1, 0};
    tbl[5] = '{1, 1, 32'h34, 32'h44, 0, 1};
    tbl[6] = '{0, 0, 32'h38, 32'h48, 0, 0};

    for (int i = 0; i < 2; i++) model_reset(i);
    step(0, 1, 0, 32'h4, 0, 1, 0, 32'h8, 0, 0);
    step(0, 1, 0, 32'h4, 0, 1, 0, 32'h8, 0, 0);

    for (int t = 0; t < 7; t++) begin
      step(1, tbl[t].v0, 1, tbl[t].a0, 32'hA000 + t, tbl[t].v1, 1, tbl[t].a1,
           32'hB000 + t, $urandom);
      chk("tbl_ready0", t, a_m0_ready, tbl[t].r0);
      chk("tbl_ready1", t, a_m1_ready, tbl[t].r1);
      chk("tbl_ready0", t, b_m0_ready, tbl[t].r0);
      chk("tbl_ready1", t, b_m1_ready, tbl[t].r1);
      idle_steps(1);
    end

    // Reset held across a pending read drops it; the next request wins at once.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 32'h100, 0, 0, 0, 0, 0, 0);
    idle_steps(1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h77);
    chk("rst_rvalid0", 0, a_m0_rvalid, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h77);
    chk("rst_mem_addr", 0, a_mem_addr, 0);
    step(1, 0, 0, 0, 0, 1, 0, 32'h200, 0, 0);
    chk("post_rst_ready1", 0, a_m1_ready, 1);
    idle_steps(5);

    // Port 0 read.
    step(1, 1, 0, 32'h2000, 0, 0, 0, 0, 0, 0);
    chk("rd_ready0", 0, a_m0_ready, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rd_mem_en", 0, a_mem_en, 1);
    chk("rd_mem_we", 0, a_mem_we, 0);
    chk("rd_mem_addr", 0, a_mem_addr, 32'h2000);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h5);
    chk("rd_rvalid0", 0, a_m0_rvalid, 1);
    chk("rd_rdata0", 0, a_m0_rdata, 32'h5);
    chk("rd_rvalid1", 0, a_m1_rvalid, 0);
    idle_steps(2);

    // Port 1 write, then the arbiter is free again two cycles after accept.
    step(1, 0, 0, 0, 0, 1, 1, 32'h2004, 32'h6, 0);
    chk("wr_ready1", 0, a_m1_ready, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("wr_mem_en", 0, a_mem_en, 1);
    chk("wr_mem_we", 0, a_mem_we, 1);
    chk("wr_mem_addr", 0, a_mem_addr, 32'h2004);
    chk("wr_mem_wdata", 0, a_mem_wdata, 32'h6);
    step(1, 1, 1, 32'h2008, 32'h9, 0, 0, 0, 0, 0);
    chk("wr_rvalid", 0, {a_m0_rvalid, a_m1_rvalid}, 0);
    chk("wr_idle_ready0", 0, a_m0_ready, 1);
    idle_steps(1);

    // Contention: both ports read continuously from reset.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ng = 0;
    nrv = 0;
    for (int k = 0; k < 40 && nrv < 4; k++) begin
      step(1, 1, 0, 32'h300, 0, 1, 0, 32'h400, 0, $urandom);
      if (a_m0_ready && ng < 8) begin gseq[ng] = 0; ng++; q.push_back(0); end
      if (a_m1_ready && ng < 8) begin gseq[ng] = 1; ng++; q.push_back(1); end
      if (a_m0_rvalid || a_m1_rvalid) begin
        own = (q.size() > 0) ? q.pop_front() : !a_m1_rvalid;
        chk("rv_owner", nrv, a_m1_rvalid, own);
        nrv++;
      end
    end
    chk("rv_count", 0, nrv, 4);
    for (int j = 0; j < 4; j++) chk("gnt_order", j, (j < ng) ? gseq[j] : -1, j % 2);
    idle_steps(6);

    // Back-to-back m0 reads on the READ_LAT=3 instance.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      step(1, 1, 0, 32'h500, 0, 0, 0, 0, 0, $urandom);
      if (b_m0_ready) gc.push_back(cyc);
      if (b_m0_rvalid) rc.push_back(cyc);
    end
    chk("lat3_rvalid", 0, (gc.size() > 0 && rc.size() > 0) ? rc[0] - gc[0] : -1, 4);
    chk("lat3_next_gnt", 0, (gc.size() > 1) ? gc[1] - gc[0] : -1, 5);
    idle_steps(6);

`ifdef DMEM_ARB_CNT_EN
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int j = 0; j < 5; j++) begin
      step(1, 1, 1, 32'h600 + j, j, 0, 0, 0, 0, 0);
      idle_steps(1);
    end
    for (int j = 0; j < 3; j++) begin
      step(1, 0, 0, 0, 0, 1, 1, 32'h700 + j, j, 0);
      idle_steps(1);
    end
    idle_steps(1);
    chk("cnt0_five", 0, a_cnt0, 5);
    chk("cnt1_three", 0, a_cnt1, 3);
    u_a.cnt0_q = 16'hFFFF;
    cnt0_m[0] = 65535;
    step(1, 1, 1, 32'h800, 0, 0, 0, 0, 0, 0);
    idle_steps(1);
    chk("cnt0_sat", 0, a_cnt0, 16'hFFFF);
`endif

    // Randomised traffic with occasional reset pulses.
    for (int k = 0; k < 800; k++) begin
      step(($urandom_range(0, 127) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
